// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: resolves STEPS_PER_CYCLE quotient bits per clock behind a ready/start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division); otherwise unsigned only.
module seq_divider #(
  parameter int WIDTH           = 24,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);
  localparam int SPC = (STEPS_PER_CYCLE < 1) ? 1 : STEPS_PER_CYCLE;
  localparam int K   = WIDTH / SPC;
  localparam int CW  = $clog2(K + 1);

  if (WIDTH < 2 || STEPS_PER_CYCLE < 1 || (WIDTH % SPC) != 0) begin : g_bad_cfg
    $error("seq_divider: WIDTH must be >= 2 and a multiple of STEPS_PER_CYCLE");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_n, r_d, r_q, r_q_o, r_r_o;
  logic [WIDTH:0]   r_p;
  logic [CW-1:0]    r_cnt;
  logic             r_dbz;

  logic [WIDTH-1:0] w_n_mag, w_d_mag, w_n_step, w_q_step, w_q_fin, w_r_fin;
  logic [WIDTH:0]   w_p_step, w_pp;
  logic             w_qbit, w_d_zero, w_last;

  assign w_d_zero    = (D == '0);
  assign w_last      = (r_cnt == CW'(1));
  assign Q           = r_q_o;
  assign R           = r_r_o;
  assign div_by_zero = r_dbz;

`ifdef DIVIDER_SIGNED_EN
  logic r_q_neg, r_r_neg;

  assign w_n_mag = N[WIDTH-1] ? -N : N;
  assign w_d_mag = D[WIDTH-1] ? -D : D;
  assign w_q_fin = r_q_neg ? -w_q_step : w_q_step;
  assign w_r_fin = r_r_neg ? -w_p_step[WIDTH-1:0] : w_p_step[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_q_neg <= N[WIDTH-1] ^ D[WIDTH-1];
      r_r_neg <= N[WIDTH-1];
    end
  end
`else
  assign w_n_mag = N;
  assign w_d_mag = D;
  assign w_q_fin = w_q_step;
  assign w_r_fin = w_p_step[WIDTH-1:0];
`endif

  // STEPS_PER_CYCLE restoring steps chained combinationally within one clock.
  always_comb begin
    w_p_step = r_p;
    w_n_step = r_n;
    w_q_step = r_q;
    w_pp     = '0;
    w_qbit   = 1'b0;
    for (int s = 0; s < SPC; s++) begin
      w_pp     = {w_p_step[WIDTH-1:0], w_n_step[WIDTH-1]};
      w_n_step = w_n_step << 1;
      w_qbit   = (w_pp >= {1'b0, r_d});
      w_p_step = w_qbit ? (w_pp - {1'b0, r_d}) : w_pp;
      w_q_step = {w_q_step[WIDTH-2:0], w_qbit};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = (r_state == S_IDLE) && !rst;
    busy        = (r_state == S_RUN);
    done        = (r_state == S_DONE);
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_d_zero ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n   <= '0;
      r_d   <= '0;
      r_p   <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_q_o <= '0;
      r_r_o <= '0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_n   <= w_n_mag;
          r_d   <= w_d_mag;
          r_p   <= '0;
          r_q   <= '0;
          r_cnt <= CW'(K);
          r_dbz <= w_d_zero;
          // Divide by zero skips RUN, so its results are registered right here.
          if (w_d_zero) begin
            r_q_o <= '1;
            r_r_o <= N;
          end
        end
        S_RUN: begin
          r_n   <= w_n_step;
          r_p   <= w_p_step;
          r_q   <= w_q_step;
          r_cnt <= r_cnt - 1'b1;
          if (w_last) begin
            r_q_o <= w_q_fin;
            r_r_o <= w_r_fin;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench: two WIDTH=8 dividers (1 and 2 steps per clock); expected results queued at start, checked at done.
module tb_seq_divider;
  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i [2];
  logic [7:0] n_i     [2];
  logic [7:0] d_i     [2];
  logic       ready_o [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic [7:0] q_o     [2];
  logic [7:0] r_o     [2];
  logic       dbz_o   [2];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  logic [7:0] hold_q [2];
  logic [7:0] hold_r [2];
  logic       prev_done [2];

  seq_divider #(.WIDTH(8), .STEPS_PER_CYCLE(1)) u_div1 (
    .clk(clk), .rst(rst), .start(start_i[0]), .N(n_i[0]), .D(d_i[0]),
    .ready(ready_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .Q(q_o[0]), .R(r_o[0]), .div_by_zero(dbz_o[0]));

  seq_divider #(.WIDTH(8), .STEPS_PER_CYCLE(2)) u_div2 (
    .clk(clk), .rst(rst), .start(start_i[1]), .N(n_i[1]), .D(d_i[1]),
    .ready(ready_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .Q(q_o[1]), .R(r_o[1]), .div_by_zero(dbz_o[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [7:0] n, input logic [7:0] d);
    exp_t m;
    int   sn, sd;
    m.due = 0;
    if (d == 8'd0) begin
      m.q = 8'hFF; m.r = n; m.dbz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sn = int'($signed(n));
      sd = int'($signed(d));
`else
      sn = int'(n);
      sd = int'(d);
`endif
      m.q = 8'(sn / sd); m.r = 8'(sn % sd); m.dbz = 1'b0;
    end
    return m;
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic do_op(input int u, input logic [7:0] n, input logic [7:0] d, input bit track);
    exp_t e;
    int   guard = 0;
    int   k = (u == 0) ? 8 : 4;
    while (!ready_o[u]) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        check("ready_timeout", 32'd0, 32'd1);
        return;
      end
    end
    start_i[u] = 1'b1; n_i[u] = n; d_i[u] = d;
    if (track) begin
      e = model(n, d);
      // done is visible in the cycle after edge (accept + K), or right after the accept edge for D==0.
      e.due = cyc + 1 + ((d == 8'd0) ? 0 : k);
      if (u == 0) sb0.push_back(e); else sb1.push_back(e);
    end
    @(negedge clk);
    start_i[u] = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        hold_q[u] = 8'd0; hold_r[u] = 8'd0; prev_done[u] = 1'b0;
      end else begin
        if (prev_done[u]) check("ready_after_done", 32'(ready_o[u]), 32'd1);
        if (busy_o[u]) begin
          check("q_stable_run", 32'(q_o[u]), 32'(hold_q[u]));
          check("r_stable_run", 32'(r_o[u]), 32'(hold_r[u]));
        end
        if (done_o[u]) begin
          if ((u == 0 && sb0.size() == 0) || (u == 1 && sb1.size() == 0)) begin
            check("spurious_done", 32'd1, 32'd0);
          end else begin
            e = (u == 0) ? sb0.pop_front() : sb1.pop_front();
            check("quotient", 32'(q_o[u]), 32'(e.q));
            check("remainder", 32'(r_o[u]), 32'(e.r));
            check("div_by_zero", 32'(dbz_o[u]), 32'(e.dbz));
            check("latency", 32'(cyc), 32'(e.due));
            hold_q[u] = e.q; hold_r[u] = e.r;
          end
        end
        prev_done[u] = done_o[u];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    for (int u = 0; u < 2; u++) begin
      start_i[u] = 1'b0; n_i[u] = 8'd0; d_i[u] = 8'd0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_ready", 32'(ready_o[u]), 32'd0);
      check("rst_busy", 32'(busy_o[u]), 32'd0);
      check("rst_done", 32'(done_o[u]), 32'd0);
      check("rst_q", 32'(q_o[u]), 32'd0);
      check("rst_r", 32'(r_o[u]), 32'd0);
      check("rst_dbz", 32'(dbz_o[u]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready_o[0]), 32'd1);

    do_op(0, 8'd200, 8'd7, 1'b1);
    do_op(1, 8'd255, 8'd16, 1'b1);
    do_op(1, 8'd5, 8'd9, 1'b1);
    do_op(0, 8'h5A, 8'd0, 1'b1);
    do_op(0, 8'd9, 8'd3, 1'b1);

    // Starts hammered through every RUN and DONE cycle must all be dropped.
    do_op(0, 8'd123, 8'd11, 1'b1);
    for (int i = 0; i < 9; i++) begin
      start_i[0] = 1'b1; n_i[0] = 8'($urandom); d_i[0] = 8'($urandom);
      @(negedge clk);
    end
    start_i[0] = 1'b0;
    @(negedge clk);

    do_op(0, 8'd50, 8'd3, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", 32'(done_o[0]), 32'd0);
    check("abort_busy", 32'(busy_o[0]), 32'd0);
    check("abort_q", 32'(q_o[0]), 32'd0);
    check("abort_r", 32'(r_o[0]), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    do_op(0, 8'd100, 8'd10, 1'b1);

    do_op(0, 8'hF9, 8'h02, 1'b1);
    do_op(0, 8'h07, 8'hFE, 1'b1);
    do_op(0, 8'h80, 8'hFF, 1'b1);
    for (int i = 0; i < 6; i++) begin
      do_op(0, 8'($urandom), 8'($urandom_range(0, 255)), 1'b1);
      do_op(1, 8'($urandom), 8'($urandom_range(0, 255)), 1'b1);
    end

    guard = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb0.size() != 0 || sb1.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    repeat (12) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
